// File: rtl/lzw_pkg.sv
// Shared types and helpers for the LZW dictionary datapath: fetch FSM states,
// string/code operation encodings and dictionary record layout helpers.
package lzw_pkg;

  typedef enum logic [2:0] {
    F_IDLE,
    F_HDR,
    F_DATA,
    F_CMP,
    F_DONE
  } fetch_state_t;

  typedef enum logic [2:0] {
    STR_NOP,
    STR_ZERO,
    STR_CHAR,
    STR_CAT,
    STR_SHR
  } str_op_t;

  typedef enum logic [1:0] {
    CODE_NOP,
    CODE_ZERO,
    CODE_INC
  } code_op_t;

  // Record header: size field in the MSBs, code field in the LSBs.
  localparam int HDR_CODE_LSB = 0;

  function automatic int hdr_size_lsb(input int ram_w, input int size_w);
    return ram_w - size_w;
  endfunction

  // Number of data words holding 'size' symbols at 'cpw' symbols per word.
  function automatic int unsigned words_for(input int unsigned size, input int unsigned cpw);
    return (size + cpw - 1) / cpw;
  endfunction

endpackage

// File: rtl/lzw_rec_fetch.sv
// Record-fetch engine: reads one dictionary record (header + data words) over
// a request/valid RAM handshake, compares it against the current string and
// reports match, record code and the address of the following record.
module lzw_rec_fetch
  import lzw_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int MAX_STR = 16,
  parameter int RAM_W   = 18,
  parameter int ADDR_W  = 18,
  parameter int CODE_W  = 12,
  parameter int SIZE_W  = $clog2(MAX_STR + 1),
  parameter int CPW     = RAM_W / CHAR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         dic_ptr,
  input  logic [ADDR_W-1:0]         ins_ptr,
  input  logic [MAX_STR*CHAR_W-1:0] str,
  input  logic [SIZE_W-1:0]         str_size,
  output logic                      ram_rd_req,
  output logic [ADDR_W-1:0]         ram_addr,
  input  logic                      ram_rd_valid,
  input  logic [RAM_W-1:0]          ram_rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      match,
  output logic                      at_end,
  output logic [CODE_W-1:0]         rec_code,
  output logic [ADDR_W-1:0]         next_addr
);

  localparam int WORD_BITS = CPW * CHAR_W;
  localparam int WORDS_MAX = int'(words_for(MAX_STR, CPW));
  localparam int SR_W      = WORDS_MAX * WORD_BITS;
  localparam int K_W       = $clog2(WORDS_MAX + 1);
  localparam int SIZE_LSB  = hdr_size_lsb(RAM_W, SIZE_W);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [SIZE_W-1:0] rec_size_q;
  logic [CODE_W-1:0] rec_code_q;
  logic [K_W-1:0]    rec_words_q;
  logic [K_W-1:0]    k_q;
  logic [SR_W-1:0]   sr_q;
  logic              match_q;
  logic              at_end_q;

  logic [SIZE_W-1:0] hdr_size;
  logic [CODE_W-1:0] hdr_code;
  logic [K_W-1:0]    hdr_words;
  logic [SR_W-1:0]   rec_aligned;
  logic [SR_W-1:0]   len_mask;
  logic [SR_W-1:0]   str_ext;
  logic              cmp_eq;

  assign hdr_size  = ram_rd_data[SIZE_LSB +: SIZE_W];
  assign hdr_code  = ram_rd_data[HDR_CODE_LSB +: CODE_W];
  assign hdr_words = K_W'(words_for(32'(hdr_size), CPW));

  // Align the received symbols (last word may carry trailing padding) with the
  // string, whose newest symbol sits in the LSBs, and compare rec_size symbols.
  // NOTE: every variable written here gets a value first, so no latch is inferred.
  always_comb begin
    rec_aligned = sr_q >> (CHAR_W * (32'(rec_words_q) * CPW - 32'(rec_size_q)));
    len_mask    = {SR_W{1'b1}} >> (SR_W - CHAR_W * 32'(rec_size_q));
    str_ext     = SR_W'(str);
    cmp_eq      = ((rec_aligned ^ str_ext) & len_mask) == '0;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= F_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE: if (start) state_d = (dic_ptr == ins_ptr) ? F_DONE : F_HDR;
      F_HDR: begin
        if (ram_rd_valid) begin
          if (hdr_size != str_size) state_d = F_DONE;
          else if (hdr_size == '0)  state_d = F_CMP;
          else                      state_d = F_DATA;
        end
      end
      F_DATA:  if (ram_rd_valid && (k_q == rec_words_q - K_W'(1))) state_d = F_CMP;
      F_CMP:   state_d = F_DONE;
      F_DONE:  state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  // Outputs decoded from the current state; address stays stable while requesting.
  always_comb begin
    ram_rd_req = 1'b0;
    ram_addr   = base_q;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      F_HDR: begin
        ram_rd_req = 1'b1;
        busy       = 1'b1;
      end
      F_DATA: begin
        ram_rd_req = 1'b1;
        busy       = 1'b1;
        ram_addr   = base_q + ADDR_W'(1) + ADDR_W'(k_q);
      end
      F_CMP:   busy = 1'b1;
      F_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Record capture: base address, header fields, data shift register and result.
  // NOTE: datapath registers are reset too, so results read as zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q      <= '0;
      rec_size_q  <= '0;
      rec_code_q  <= '0;
      rec_words_q <= '0;
      k_q         <= '0;
      sr_q        <= '0;
      match_q     <= 1'b0;
      at_end_q    <= 1'b0;
    end else begin
      case (state_q)
        F_IDLE: begin
          if (start) begin
            base_q      <= dic_ptr;
            rec_size_q  <= '0;
            rec_code_q  <= '0;
            rec_words_q <= '0;
            match_q     <= 1'b0;
            at_end_q    <= (dic_ptr == ins_ptr);
          end
        end
        F_HDR: begin
          if (ram_rd_valid) begin
            rec_size_q  <= hdr_size;
            rec_code_q  <= hdr_code;
            rec_words_q <= hdr_words;
            k_q         <= '0;
            sr_q        <= '0;
          end
        end
        F_DATA: begin
          if (ram_rd_valid) begin
            sr_q <= (sr_q << WORD_BITS) | SR_W'(ram_rd_data[WORD_BITS-1:0]);
            k_q  <= k_q + K_W'(1);
          end
        end
        F_CMP:   match_q <= cmp_eq;
        default: ;
      endcase
    end
  end

  assign match     = match_q;
  assign at_end    = at_end_q;
  assign rec_code  = rec_code_q;
  assign next_addr = base_q + ADDR_W'(1) + ADDR_W'(words_for(32'(rec_size_q), CPW));

endmodule

// File: rtl/lzw_dict_datapath.sv
// LZW compressor datapath: current string and its size, code counter,
// dictionary/insert pointers, plus the autonomous record-fetch engine.
module lzw_dict_datapath
  import lzw_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int MAX_STR = 16,
  parameter int RAM_W   = 18,
  parameter int ADDR_W  = 18,
  parameter int CODE_W  = 12,
  parameter int SIZE_W  = $clog2(MAX_STR + 1),
  parameter int CPW     = RAM_W / CHAR_W
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [CHAR_W-1:0]         iChar,
  input  logic [ADDR_W-1:0]         iInitPtr,
  input  logic                      iStrLoadZero,
  input  logic                      iStrLoadChar,
  input  logic                      iStrConcat,
  input  logic                      iStrShiftRight,
  input  logic                      iCodeLoadZero,
  input  logic                      iCodeInc,
  input  logic                      iLoadDicPtr,
  input  logic                      iDicPtrNext,
  input  logic                      iLoadInsPtr,
  input  logic                      iInsPtrUpdate,
  input  logic                      iFetchStart,
  output logic                      oRamRdReq,
  output logic [ADDR_W-1:0]         oRamAddr,
  input  logic                      iRamRdValid,
  input  logic [RAM_W-1:0]          iRamRdData,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oMatch,
  output logic                      oAtEnd,
  output logic [CODE_W-1:0]         oRecCode,
  output logic [CODE_W-1:0]         oCode,
  output logic                      oDictFull,
  output logic                      oStrOvf,
  output logic [SIZE_W-1:0]         oStrSize,
  output logic [MAX_STR*CHAR_W-1:0] oString,
  output logic [ADDR_W-1:0]         oDicPtr,
  output logic [ADDR_W-1:0]         oInsPtr
);

  localparam int STR_W = MAX_STR * CHAR_W;

  if (SIZE_W + CODE_W > RAM_W) begin : g_bad_hdr
    $error("record header {size, code} does not fit in a RAM word");
  end
  if (CPW < 1) begin : g_bad_cpw
    $error("RAM word narrower than one symbol");
  end

  logic [STR_W-1:0]  str_q;
  logic [SIZE_W-1:0] size_q;
  logic              ovf_q;
  logic [CODE_W-1:0] code_q;
  logic [ADDR_W-1:0] dic_ptr_q;
  logic [ADDR_W-1:0] ins_ptr_q;

  str_op_t           str_op;
  code_op_t          code_op;
  logic [STR_W-1:0]  oldest_mask;
  logic              code_full;
  logic              busy;
  logic [ADDR_W-1:0] next_addr;

  // String and code operation decode by priority; mask of the oldest symbol.
  always_comb begin
    str_op = STR_NOP;
    if      (iStrLoadZero)   str_op = STR_ZERO;
    else if (iStrLoadChar)   str_op = STR_CHAR;
    else if (iStrConcat)     str_op = STR_CAT;
    else if (iStrShiftRight) str_op = STR_SHR;

    code_op = CODE_NOP;
    if      (iCodeLoadZero) code_op = CODE_ZERO;
    else if (iCodeInc)      code_op = CODE_INC;

    oldest_mask = STR_W'({CHAR_W{1'b1}}) << (CHAR_W * (32'(size_q) - 1));
  end

  assign code_full = (code_q == {CODE_W{1'b1}});

  // Current string: frozen while a fetch compares against it; overflow is sticky.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      str_q  <= '0;
      size_q <= '0;
      ovf_q  <= 1'b0;
    end else if (!busy) begin
      case (str_op)
        STR_ZERO: begin
          str_q  <= '0;
          size_q <= '0;
        end
        STR_CHAR: begin
          str_q  <= STR_W'(iChar);
          size_q <= SIZE_W'(1);
        end
        STR_CAT: begin
          if (size_q == SIZE_W'(MAX_STR)) begin
            ovf_q <= 1'b1;
          end else begin
            str_q  <= (str_q << CHAR_W) | STR_W'(iChar);
            size_q <= size_q + SIZE_W'(1);
          end
        end
        STR_SHR: begin
          if (size_q != '0) begin
            str_q  <= str_q & ~oldest_mask;
            size_q <= size_q - SIZE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Code counter saturates at the all-ones code instead of wrapping.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      code_q <= '0;
    end else begin
      case (code_op)
        CODE_ZERO: code_q <= '0;
        CODE_INC:  if (!code_full) code_q <= code_q + CODE_W'(1);
        default: ;
      endcase
    end
  end

  // Dictionary and insert pointers, all arithmetic modulo 2**ADDR_W.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dic_ptr_q <= '0;
      ins_ptr_q <= '0;
    end else begin
      if      (iLoadDicPtr) dic_ptr_q <= iInitPtr;
      else if (iDicPtrNext) dic_ptr_q <= next_addr;

      if (iLoadInsPtr)
        ins_ptr_q <= dic_ptr_q;
      else if (iInsPtrUpdate)
        ins_ptr_q <= ins_ptr_q + ADDR_W'(1) + ADDR_W'(words_for(32'(size_q), CPW));
    end
  end

  lzw_rec_fetch #(
    .CHAR_W  (CHAR_W),
    .MAX_STR (MAX_STR),
    .RAM_W   (RAM_W),
    .ADDR_W  (ADDR_W),
    .CODE_W  (CODE_W),
    .SIZE_W  (SIZE_W),
    .CPW     (CPW)
  ) u_fetch (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .start        (iFetchStart),
    .dic_ptr      (dic_ptr_q),
    .ins_ptr      (ins_ptr_q),
    .str          (str_q),
    .str_size     (size_q),
    .ram_rd_req   (oRamRdReq),
    .ram_addr     (oRamAddr),
    .ram_rd_valid (iRamRdValid),
    .ram_rd_data  (iRamRdData),
    .busy         (busy),
    .done         (oDone),
    .match        (oMatch),
    .at_end       (oAtEnd),
    .rec_code     (oRecCode),
    .next_addr    (next_addr)
  );

  assign oBusy     = busy;
  assign oCode     = code_q;
  assign oDictFull = code_full;
  assign oStrOvf   = ovf_q;
  assign oStrSize  = size_q;
  assign oString   = str_q;
  assign oDicPtr   = dic_ptr_q;
  assign oInsPtr   = ins_ptr_q;

endmodule

// File: tb/tb_lzw_dict_datapath.sv
// Self-checking bench for lzw_dict_datapath: string/code/pointer operations
// and record fetches against a behavioural RAM with programmable wait states.
module tb_lzw_dict_datapath;

  localparam int CHAR_W  = 8;
  localparam int MAX_STR = 16;
  localparam int SIZE_W  = 5;
  localparam int RAM_W   = 18;
  localparam int ADDR_W  = 18;
  localparam int CODE_W  = 12;
  localparam int STR_W   = MAX_STR * CHAR_W;

  localparam logic [9:0] OP_SZERO = 10'h001;
  localparam logic [9:0] OP_SCHAR = 10'h002;
  localparam logic [9:0] OP_SCAT  = 10'h004;
  localparam logic [9:0] OP_SSHR  = 10'h008;
  localparam logic [9:0] OP_CZERO = 10'h010;
  localparam logic [9:0] OP_CINC  = 10'h020;
  localparam logic [9:0] OP_LDIC  = 10'h040;
  localparam logic [9:0] OP_NDIC  = 10'h080;
  localparam logic [9:0] OP_LINS  = 10'h100;
  localparam logic [9:0] OP_UINS  = 10'h200;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic [CHAR_W-1:0]  iChar;
  logic [ADDR_W-1:0]  iInitPtr;
  logic               iStrLoadZero, iStrLoadChar, iStrConcat, iStrShiftRight;
  logic               iCodeLoadZero, iCodeInc;
  logic               iLoadDicPtr, iDicPtrNext, iLoadInsPtr, iInsPtrUpdate;
  logic               iFetchStart;
  logic               oRamRdReq;
  logic [ADDR_W-1:0]  oRamAddr;
  logic               iRamRdValid;
  logic [RAM_W-1:0]   iRamRdData;
  logic               oBusy, oDone, oMatch, oAtEnd;
  logic [CODE_W-1:0]  oRecCode, oCode;
  logic               oDictFull, oStrOvf;
  logic [SIZE_W-1:0]  oStrSize;
  logic [STR_W-1:0]   oString;
  logic [ADDR_W-1:0]  oDicPtr, oInsPtr;

  always #5 Clk = ~Clk;

  lzw_dict_datapath dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .iChar          (iChar),
    .iInitPtr       (iInitPtr),
    .iStrLoadZero   (iStrLoadZero),
    .iStrLoadChar   (iStrLoadChar),
    .iStrConcat     (iStrConcat),
    .iStrShiftRight (iStrShiftRight),
    .iCodeLoadZero  (iCodeLoadZero),
    .iCodeInc       (iCodeInc),
    .iLoadDicPtr    (iLoadDicPtr),
    .iDicPtrNext    (iDicPtrNext),
    .iLoadInsPtr    (iLoadInsPtr),
    .iInsPtrUpdate  (iInsPtrUpdate),
    .iFetchStart    (iFetchStart),
    .oRamRdReq      (oRamRdReq),
    .oRamAddr       (oRamAddr),
    .iRamRdValid    (iRamRdValid),
    .iRamRdData     (iRamRdData),
    .oBusy          (oBusy),
    .oDone          (oDone),
    .oMatch         (oMatch),
    .oAtEnd         (oAtEnd),
    .oRecCode       (oRecCode),
    .oCode          (oCode),
    .oDictFull      (oDictFull),
    .oStrOvf        (oStrOvf),
    .oStrSize       (oStrSize),
    .oString        (oString),
    .oDicPtr        (oDicPtr),
    .oInsPtr        (oInsPtr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural RAM: answers a held request after ram_delay wait cycles.
  logic [RAM_W-1:0] mem [0:63];
  int  ram_delay   = 0;
  int  wait_cnt    = 0;
  int  rd_cnt      = 0;
  bit  req_seen    = 0;
  bit  inject_valid = 0;

  always @(negedge Clk) begin
    iRamRdValid = 1'b0;
    if (inject_valid) begin
      iRamRdValid = 1'b1;
      iRamRdData  = {2'b00, 16'h4142};
    end else if (oRamRdReq) begin
      req_seen = 1;
      if (wait_cnt >= ram_delay) begin
        iRamRdValid = 1'b1;
        iRamRdData  = mem[oRamAddr[5:0]];
        rd_cnt++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  function automatic logic [RAM_W-1:0] hdr(input int size, input int code);
    return {5'(size), 1'b0, 12'(code)};
  endfunction

  // Scoreboard of expected fetch results.
  typedef struct {
    logic        match;
    logic [11:0] code;
    logic        at_end;
    int          reads;
  } fetch_exp_t;

  fetch_exp_t exp_q[$];

  task automatic op(input logic [9:0] ops, input logic [7:0] ch = 8'h00);
    {iInsPtrUpdate, iLoadInsPtr, iDicPtrNext, iLoadDicPtr, iCodeInc, iCodeLoadZero,
     iStrShiftRight, iStrConcat, iStrLoadChar, iStrLoadZero} = ops;
    iChar = ch;
    @(negedge Clk);
    {iInsPtrUpdate, iLoadInsPtr, iDicPtrNext, iLoadDicPtr, iCodeInc, iCodeLoadZero,
     iStrShiftRight, iStrConcat, iStrLoadChar, iStrLoadZero} = '0;
  endtask

  task automatic load_dic(input logic [ADDR_W-1:0] a);
    iInitPtr = a;
    op(OP_LDIC);
  endtask

  task automatic run_fetch(input string tag, input logic m, input logic [11:0] c,
                           input logic e, input int reads, input bit poke_concat,
                           input int exp_lat);
    fetch_exp_t x;
    bit got;
    int lat;
    x.match = m; x.code = c; x.at_end = e; x.reads = reads;
    exp_q.push_back(x);
    rd_cnt   = 0;
    req_seen = 0;
    iFetchStart = 1'b1;
    @(negedge Clk);
    iFetchStart = 1'b0;
    if (poke_concat) op(OP_SCAT, 8'h5A);
    got = 0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (oDone) begin
        got = 1;
        lat = i;
        break;
      end
      @(negedge Clk);
    end
    check({tag, "_done_seen"}, 128'(got), 128'(1));
    x = exp_q.pop_front();
    if (got) begin
      check({tag, "_match"},  128'(oMatch),   128'(x.match));
      check({tag, "_code"},   128'(oRecCode), 128'(x.code));
      check({tag, "_at_end"}, 128'(oAtEnd),   128'(x.at_end));
      check({tag, "_reads"},  128'(rd_cnt),   128'(x.reads));
      if (exp_lat >= 0) check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    end
    @(negedge Clk);
    check({tag, "_done_pulse"}, 128'(oDone), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [STR_W-1:0] exp_str;
    bit found;

    Reset_n = 1'b0;
    iChar = '0; iInitPtr = '0; iFetchStart = 1'b0;
    {iInsPtrUpdate, iLoadInsPtr, iDicPtrNext, iLoadDicPtr, iCodeInc, iCodeLoadZero,
     iStrShiftRight, iStrConcat, iStrLoadChar, iStrLoadZero} = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h10] = hdr(3, 12'h101); mem[6'h11] = 18'h04142; mem[6'h12] = 18'h04399;
    mem[6'h13] = hdr(2, 12'h102); mem[6'h14] = 18'h04142;
    mem[6'h15] = hdr(3, 12'h103); mem[6'h16] = 18'h04142; mem[6'h17] = 18'h04400;

    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    check("rst_size",   128'(oStrSize),  128'(0));
    check("rst_string", 128'(oString),   128'(0));
    check("rst_code",   128'(oCode),     128'(0));
    check("rst_dicptr", 128'(oDicPtr),   128'(0));
    check("rst_insptr", 128'(oInsPtr),   128'(0));
    check("rst_req",    128'(oRamRdReq), 128'(0));
    check("rst_done",   128'(oDone),     128'(0));
    check("rst_ovf",    128'(oStrOvf),   128'(0));
    check("rst_busy",   128'(oBusy),     128'(0));

    // Build "ABC".
    op(OP_SCHAR, 8'h41); op(OP_SCAT, 8'h42); op(OP_SCAT, 8'h43);
    check("abc_size",   128'(oStrSize), 128'(3));
    check("abc_string", 128'(oString),  128'(24'h414243));

    // Pointers.
    load_dic(18'h10);
    check("dic_load", 128'(oDicPtr), 128'(18'h10));
    op(OP_LINS);
    check("ins_load", 128'(oInsPtr), 128'(18'h10));
    op(OP_UINS); op(OP_UINS);
    check("ins_update", 128'(oInsPtr), 128'(18'h16));

    // Matching 3-symbol record with a padded last word.
    run_fetch("fetch_abc", 1'b1, 12'h101, 1'b0, 3, 0, 4);
    op(OP_NDIC);
    check("next_after_abc", 128'(oDicPtr), 128'(18'h13));

    // Size mismatch: header read only.
    run_fetch("fetch_size_mis", 1'b0, 12'h102, 1'b0, 1, 0, -1);
    op(OP_NDIC);
    check("next_after_size_mis", 128'(oDicPtr), 128'(18'h15));

    // Same size, differing last symbol; string ops ignored while busy.
    run_fetch("fetch_data_mis", 1'b0, 12'h103, 1'b0, 3, 1, -1);
    check("busy_ignore_size",   128'(oStrSize), 128'(3));
    check("busy_ignore_string", 128'(oString),  128'(24'h414243));

    op(OP_SSHR);
    check("shr_size",   128'(oStrSize), 128'(2));
    check("shr_string", 128'(oString),  128'(16'h4243));

    // Even-length match "AB".
    op(OP_SCHAR, 8'h41); op(OP_SCAT, 8'h42);
    load_dic(18'h13);
    run_fetch("fetch_ab", 1'b1, 12'h102, 1'b0, 2, 0, 3);

    // DicPtr == InsPtr: end of dictionary, no RAM access.
    load_dic(18'h16);
    run_fetch("fetch_at_end", 1'b0, 12'h000, 1'b1, 0, 0, 0);
    check("at_end_no_req", 128'(req_seen), 128'(0));

    // Code counter and saturation.
    op(OP_CZERO);
    repeat (3) op(OP_CINC);
    check("code_3",      128'(oCode),     128'(3));
    check("code_3_full", 128'(oDictFull), 128'(0));
    repeat (4092) op(OP_CINC);
    check("code_max",      128'(oCode),     128'(12'hFFF));
    check("code_max_full", 128'(oDictFull), 128'(1));
    op(OP_CINC);
    check("code_no_wrap", 128'(oCode), 128'(12'hFFF));
    op(OP_CZERO | OP_CINC);
    check("code_zero_prio", 128'(oCode), 128'(0));

    // String priority and empty shift.
    op(OP_SZERO | OP_SCHAR, 8'h77);
    check("str_zero_prio", 128'(oStrSize), 128'(0));
    op(OP_SSHR);
    check("shr_empty", 128'(oStrSize), 128'(0));

    // Overflow: 17 concatenations from empty.
    exp_str = '0;
    for (int i = 1; i <= 17; i++) begin
      op(OP_SCAT, 8'(i));
      if (i <= MAX_STR) exp_str = (exp_str << CHAR_W) | STR_W'(i);
    end
    check("ovf_size",   128'(oStrSize), 128'(16));
    check("ovf_flag",   128'(oStrOvf),  128'(1));
    check("ovf_string", 128'(oString),  128'(exp_str));
    op(OP_SSHR);
    exp_str[STR_W-1 -: CHAR_W] = '0;
    check("ovf_shr_size",   128'(oStrSize), 128'(15));
    check("ovf_shr_string", 128'(oString),  128'(exp_str));
    check("ovf_sticky",     128'(oStrOvf),  128'(1));

    // Reset during DATA with a 5-cycle RAM stall.
    op(OP_SCHAR, 8'h41); op(OP_SCAT, 8'h42); op(OP_SCAT, 8'h43);
    load_dic(18'h10);
    ram_delay = 5;
    iFetchStart = 1'b1;
    @(negedge Clk);
    iFetchStart = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (oRamRdReq && oBusy && (oRamAddr == 18'h11)) begin
        found = 1;
        break;
      end
      @(negedge Clk);
    end
    check("stall_data_reached", 128'(found), 128'(1));
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("midrst_req",    128'(oRamRdReq), 128'(0));
    check("midrst_busy",   128'(oBusy),     128'(0));
    check("midrst_ovf",    128'(oStrOvf),   128'(0));
    check("midrst_dicptr", 128'(oDicPtr),   128'(0));
    inject_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("late_valid_busy", 128'(oBusy),     128'(0));
      check("late_valid_done", 128'(oDone),     128'(0));
      check("late_valid_req",  128'(oRamRdReq), 128'(0));
    end
    inject_valid = 0;
    ram_delay = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
